logic_bist_controller: RTL and testbench

Sequential built-in self-test controller for the 3-input/2-output combinational gate block (e = ~c, f = (a & b) | ~c). It drives all 8 input vectors onto the block, waits a configurable settle time, and samples and checks both outputs against an internal golden model. It then reports pass/fail, a failure count and the first failing vector. It sits beside the combinational block under test: its outputs feed the block's inputs, and the block's outputs feed its sample inputs.

---
 rtl/logic_bist_pkg.sv | 15 +
 rtl/logic_bist_golden.sv | 20 ++
 rtl/logic_bist_controller.sv | 143 ++++++++++++++
 tb/tb_logic_bist_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/logic_bist_pkg.sv
// Shared types and sizing for the logic BIST controller and its golden model.
package logic_bist_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } bist_state_e;

endpackage

// File: rtl/logic_bist_golden.sv
// Golden model of the gate block under test: e = ~c, f = (a & b) | ~c, vec = {a,b,c}.
module logic_bist_golden
    import logic_bist_pkg::*;
(
    input  logic [VEC_W-1:0] vec_i,
    output logic             exp_e_o,
    output logic             exp_f_o
);

    logic a, b, c;

    always_comb begin
        a       = vec_i[2];
        b       = vec_i[1];
        c       = vec_i[0];
        exp_e_o = ~c;
        exp_f_o = (a & b) | ~c;
    end

endmodule

// File: rtl/logic_bist_controller.sv
// Sequential BIST controller for the 3-in/2-out gate block; sweeps all vectors and checks outputs.
// Optional build macro BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module logic_bist_controller
    import logic_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    input  logic             dut_e,
    input  logic             dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES);
    localparam logic [VEC_W-1:0]   LastVec    = VEC_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0]   MaxFails   = CNT_W'(NUM_VECTORS);

`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    bist_state_e        state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [CNT_W-1:0]   fail_count_q, fail_count_d;
    logic [VEC_W-1:0]   first_fail_vec_q, first_fail_vec_d;
    logic               first_fail_valid_q, first_fail_valid_d;
    logic               busy_q, done_q, pass_q;
    logic               exp_e, exp_f;
    logic               mismatch;

    logic_bist_golden u_golden (
        .vec_i   (vec_q),
        .exp_e_o (exp_e),
        .exp_f_o (exp_f)
    );

    always_comb begin
        state_d            = state_q;
        vec_d              = vec_q;
        settle_d           = settle_q;
        fail_count_d       = fail_count_q;
        first_fail_vec_d   = first_fail_vec_q;
        first_fail_valid_d = first_fail_valid_q;
        mismatch           = (dut_e != exp_e) || (dut_f != exp_f);

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d            = StDrive;
                    vec_d              = '0;
                    settle_d           = SettleLoad;
                    fail_count_d       = '0;
                    first_fail_vec_d   = '0;
                    first_fail_valid_d = 1'b0;
                end
            end
            StDrive: begin
                if (settle_q == SettleW'(1)) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q - SettleW'(1);
                end
            end
            StSample: begin
                if (mismatch) begin
                    if (fail_count_q != MaxFails) begin
                        fail_count_d = fail_count_q + CNT_W'(1);
                    end
                    if (!first_fail_valid_q) begin
                        first_fail_vec_d   = vec_q;
                        first_fail_valid_d = 1'b1;
                    end
                end
                if ((StopOnFail && mismatch) || (vec_q == LastVec)) begin
                    state_d = StDone;
                end else begin
                    state_d  = StDrive;
                    vec_d    = vec_q + VEC_W'(1);
                    settle_d = SettleLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= StIdle;
            vec_q              <= '0;
            settle_q           <= '0;
            fail_count_q       <= '0;
            first_fail_vec_q   <= '0;
            first_fail_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            vec_q              <= vec_d;
            settle_q           <= settle_d;
            fail_count_q       <= fail_count_d;
            first_fail_vec_q   <= first_fail_vec_d;
            first_fail_valid_q <= first_fail_valid_d;
        end
    end

    // Status flags are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            busy_q <= (state_q == StDrive) || (state_q == StSample);
            done_q <= (state_q == StDone);
            pass_q <= (state_q == StDone) && (fail_count_q == '0);
        end
    end

    always_comb begin
        dut_a            = vec_q[2];
        dut_b            = vec_q[1];
        dut_c            = vec_q[0];
        busy             = busy_q;
        done             = done_q;
        pass             = pass_q;
        fail_count       = fail_count_q;
        first_fail_vec   = first_fail_vec_q;
        first_fail_valid = first_fail_valid_q;
    end

endmodule

// File: tb/tb_logic_bist_controller.sv
// Directed bench for logic_bist_controller with a faultable model of the gate block.
module tb_logic_bist_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       dut_a, dut_b, dut_c;
    logic       dut_e, dut_f;
    logic       busy, done, pass;
    logic [3:0] fail_count;
    logic [2:0] first_fail_vec;
    logic       first_fail_valid;
    logic [1:0] fault;

    int checks;
    int failures;

`ifdef BIST_STOP_ON_FAIL_EN
    localparam int F0_DONE = 3;
    localparam int F0_CNT  = 1;
    localparam int EC_DONE = 3;
    localparam int EC_CNT  = 1;
    localparam int F1_DONE = 5;
    localparam int F1_CNT  = 1;
`else
    localparam int F0_DONE = 17;
    localparam int F0_CNT  = 5;
    localparam int EC_DONE = 17;
    localparam int EC_CNT  = 8;
    localparam int F1_DONE = 17;
    localparam int F1_CNT  = 3;
`endif

    logic_bist_controller #(
        .SETTLE_CYCLES (1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .dut_a            (dut_a),
        .dut_b            (dut_b),
        .dut_c            (dut_c),
        .dut_e            (dut_e),
        .dut_f            (dut_f),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    // Gate block: 0 good, 1 f stuck-0, 2 e follows c, 3 f stuck-1.
    always_comb begin
        dut_e = ~dut_c;
        dut_f = (dut_a & dut_b) | ~dut_c;
        case (fault)
            2'd1: dut_f = 1'b0;
            2'd2: dut_e = dut_c;
            2'd3: dut_f = 1'b1;
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {4'b0, busy, done, pass, first_fail_valid}, 8'h00);
        check({tag, "_fail_count"}, {4'b0, fail_count}, 8'h00);
        check({tag, "_first_vec"}, {5'b0, first_fail_vec}, 8'h00);
        check({tag, "_abc"}, {5'b0, dut_a, dut_b, dut_c}, 8'h00);
    endtask

    // Starts a run at edge T and returns after done is seen; checks done lands at T+exp_done.
    task automatic run_sweep(input string tag, input bit hold, input bit chk_vec,
                             input int exp_done);
        int n;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check({tag, "_busy_at_T"}, {7'b0, busy}, 8'h00);
        tick();
        n = 1;
        check({tag, "_busy_T1"}, {7'b0, busy}, 8'h01);
        check({tag, "_done_T1"}, {7'b0, done}, 8'h00);
        check({tag, "_cleared_T1"}, {3'b0, first_fail_valid, fail_count}, 8'h00);
        check({tag, "_vec0_T1"}, {5'b0, dut_a, dut_b, dut_c}, 8'h00);
        while (!done && n < 40) begin
            if (n == exp_done - 1) start = 1'b0;
            tick();
            n++;
            if (chk_vec && n <= 14 && (n % 2) == 0)
                check({tag, "_vec"}, {5'b0, dut_a, dut_b, dut_c}, 8'(n / 2));
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 8'(n), 8'(exp_done));
        check({tag, "_busy_at_done"}, {7'b0, busy}, 8'h00);
    endtask

    task automatic check_result(input string tag, input logic p, input logic [3:0] cnt,
                                input logic fv, input logic [2:0] vec);
        check({tag, "_pass"}, {7'b0, pass}, {7'b0, p});
        check({tag, "_fail_count"}, {4'b0, fail_count}, {4'b0, cnt});
        check({tag, "_first_valid"}, {7'b0, first_fail_valid}, {7'b0, fv});
        check({tag, "_first_vec"}, {5'b0, first_fail_vec}, {5'b0, vec});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        fault    = 2'd0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        check_zero("idle");

        fault = 2'd0;
        run_sweep("good", 1'b0, 1'b1, 17);
        check_result("good", 1'b1, 4'd0, 1'b0, 3'd0);

        fault = 2'd1;
        run_sweep("f_stuck0", 1'b0, 1'b0, F0_DONE);
        check_result("f_stuck0", 1'b0, 4'(F0_CNT), 1'b1, 3'd0);

        fault = 2'd2;
        run_sweep("e_eq_c", 1'b0, 1'b0, EC_DONE);
        check_result("e_eq_c", 1'b0, 4'(EC_CNT), 1'b1, 3'd0);

        fault = 2'd3;
        run_sweep("f_stuck1", 1'b0, 1'b0, F1_DONE);
        check_result("f_stuck1", 1'b0, 4'(F1_CNT), 1'b1, 3'd1);

        // Held in DONE, then a new good run must clear the stale failure state.
        repeat (3) tick();
        check("done_held", {7'b0, done}, 8'h01);
        fault = 2'd0;
        run_sweep("rerun", 1'b0, 1'b1, 17);
        check_result("rerun", 1'b1, 4'd0, 1'b0, 3'd0);

        // Reset while vector 4 is driven.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("midrun_vec4", {5'b0, dut_a, dut_b, dut_c}, 8'h04);
        check("midrun_busy", {7'b0, busy}, 8'h01);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("midrun_reset");
        tick();
        check("post_reset_idle", {6'b0, busy, done}, 8'h00);
        run_sweep("after_reset", 1'b0, 1'b1, 17);
        check_result("after_reset", 1'b1, 4'd0, 1'b0, 3'd0);

        run_sweep("start_held", 1'b1, 1'b1, 17);
        check_result("start_held", 1'b1, 4'd0, 1'b0, 3'd0);
        tick();
        check("no_restart", {6'b0, busy, done}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
